// File: rtl/bus_cycle_initiator.sv
// Single-beat bus master: turns read/write requests into timed address/strobe
// cycles, samples the decoder's read-only flag and suppresses ROM writes.
module bus_cycle_initiator #(
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wr_data,
  input  logic                  req_we,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rd_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  input  logic [DATA_WIDTH-1:0] bus_rd_data,
  output logic                  bus_we,
  output logic                  bus_strobe,
  input  logic                  is_readonly
);

  localparam int unsigned MAX_CYCLES = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  ro_q, ro_d;
  logic                  req_ready_d;
  logic                  resp_valid_d;
  logic                  resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rd_data_d;
  logic [ADDR_WIDTH-1:0] bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wr_data_d;
  logic                  bus_we_d;
  logic                  bus_strobe_d;

  // State and every output are registered together; the comb blocks below
  // compute their next values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      ro_q         <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rd_data <= '0;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
      bus_we       <= 1'b0;
      bus_strobe   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      ro_q         <= ro_d;
      req_ready    <= req_ready_d;
      resp_valid   <= resp_valid_d;
      resp_err     <= resp_err_d;
      resp_rd_data <= resp_rd_data_d;
      bus_addr     <= bus_addr_d;
      bus_wr_data  <= bus_wr_data_d;
      bus_we       <= bus_we_d;
      bus_strobe   <= bus_strobe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && req_ready) state_d = SETUP;
      SETUP:   if (cnt_q == '0) state_d = STROBE;
      STROBE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d          = cnt_q;
    we_d           = we_q;
    ro_d           = ro_q;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rd_data_d = resp_rd_data;
    bus_addr_d     = bus_addr;
    bus_wr_data_d  = bus_wr_data;
    bus_we_d       = bus_we;
    bus_strobe_d   = bus_strobe;
    req_ready_d    = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          bus_addr_d    = req_addr;
          bus_wr_data_d = req_wr_data;
          we_d          = req_we;
          cnt_d         = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          // The decoder flag is used directly here since ro_q only updates on this edge.
          ro_d         = is_readonly;
          bus_strobe_d = 1'b1;
          bus_we_d     = we_q & ~is_readonly;
          cnt_d        = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          if (!we_q) resp_rd_data_d = bus_rd_data;
          bus_strobe_d = 1'b0;
          bus_we_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        resp_valid_d = 1'b1;
        resp_err_d   = we_q & ro_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Directed bench for bus_cycle_initiator with a registered PET-style decoder model.
module tb_bus_cycle_initiator;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wr_data;
  logic          req_we;
  logic          resp_valid;
  logic [DW-1:0] resp_rd_data;
  logic          resp_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          bus_we;
  logic          bus_strobe;
  logic          is_readonly;
  logic [DW-1:0] rd_value;

  int total = 0;
  int bad = 0;

  bus_cycle_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETUP_CYCLES(2), .STROBE_CYCLES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_we(req_we),
    .resp_valid(resp_valid), .resp_rd_data(resp_rd_data), .resp_err(resp_err),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_we(bus_we), .bus_strobe(bus_strobe), .is_readonly(is_readonly)
  );

  always #5 clk = ~clk;

  // Memory only returns data while strobed, so a mistimed capture is visible.
  assign bus_rd_data = bus_strobe ? rd_value : '0;

  // ROM: $B000-$E7FF and $F000-$FFFF in bank 0.
  function automatic logic ro_map(input logic [AW-1:0] a);
    return !a[16] && ((a[15:0] >= 16'hB000 && a[15:0] <= 16'hE7FF) || a[15:0] >= 16'hF000);
  endfunction

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) is_readonly <= 1'b0;
    else          is_readonly <= ro_map(bus_addr);

  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       output bit accepted);
    bit rdy;
    req_addr = a; req_we = w; req_wr_data = d; req_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin accepted = 1; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (bus_strobe !== 1'b0 || bus_we !== 1'b0) begin bad++; $display("FAIL reset_strobe_we got=%b%b want=00", bus_strobe, bus_we); end
    total++; if (bus_addr !== '0 || bus_wr_data !== '0) begin bad++; $display("FAIL reset_bus got=%h/%h want=0/0", bus_addr, bus_wr_data); end
    total++; if (resp_rd_data !== '0 || resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp got=%h/%b want=00/0", resp_rd_data, resp_err); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_read;
    bit acc;
    rd_value = 8'hA5;
    issue(17'h00000, 1'b0, 8'h00, acc);
    req_valid = 1'b0;
    total++; if (!acc) begin bad++; $display("FAIL read_accept timeout"); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL read_ready_busy got=%b want=0", req_ready); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      total++; if (bus_strobe !== (k == 2 || k == 3)) begin bad++; $display("FAIL read_strobe k=%0d got=%b", k, bus_strobe); end
      total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL read_we k=%0d got=%b want=0", k, bus_we); end
      total++; if (resp_valid !== (k == 5)) begin bad++; $display("FAIL read_resp_valid k=%0d got=%b", k, resp_valid); end
      total++; if (req_ready !== (k == 5)) begin bad++; $display("FAIL read_ready k=%0d got=%b", k, req_ready); end
    end
    total++; if (resp_rd_data !== 8'hA5) begin bad++; $display("FAIL read_data got=%h want=a5", resp_rd_data); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL read_err got=%b want=0", resp_err); end
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL read_pulse_width got=%b want=0", resp_valid); end
  endtask

  task automatic test_write_ram;
    bit acc;
    rd_value = 8'h11;
    issue(17'h08123, 1'b1, 8'h3C, acc);
    req_valid = 1'b0;
    total++; if (!acc) begin bad++; $display("FAIL wram_accept timeout"); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      total++; if (bus_strobe !== (k == 2 || k == 3)) begin bad++; $display("FAIL wram_strobe k=%0d got=%b", k, bus_strobe); end
      total++; if (bus_we !== (k == 2 || k == 3)) begin bad++; $display("FAIL wram_we k=%0d got=%b", k, bus_we); end
      total++; if (bus_addr !== 17'h08123 || bus_wr_data !== 8'h3C) begin bad++; $display("FAIL wram_bus k=%0d got=%h/%h want=08123/3c", k, bus_addr, bus_wr_data); end
      total++; if (resp_valid !== (k == 5)) begin bad++; $display("FAIL wram_resp_valid k=%0d got=%b", k, resp_valid); end
    end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL wram_err got=%b want=0", resp_err); end
    total++; if (resp_rd_data !== 8'hA5) begin bad++; $display("FAIL wram_rd_kept got=%h want=a5", resp_rd_data); end
  endtask

  task automatic test_write_rom;
    bit acc;
    issue(17'h0F000, 1'b1, 8'hFF, acc);
    req_valid = 1'b0;
    total++; if (!acc) begin bad++; $display("FAIL wrom_accept timeout"); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      total++; if (bus_strobe !== (k == 2 || k == 3)) begin bad++; $display("FAIL wrom_strobe k=%0d got=%b", k, bus_strobe); end
      total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL wrom_we k=%0d got=%b want=0", k, bus_we); end
      total++; if (resp_valid !== (k == 5)) begin bad++; $display("FAIL wrom_resp_valid k=%0d got=%b", k, resp_valid); end
    end
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL wrom_err got=%b want=1", resp_err); end
  endtask

  task automatic test_back_to_back;
    bit acc;
    rd_value = 8'h5A;
    issue(17'h0E810, 1'b0, 8'h00, acc);
    total++; if (!acc) begin bad++; $display("FAIL b2b_accept timeout"); end
    req_addr = 17'h0E840; req_we = 1'b1; req_wr_data = 8'h96;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 6) req_valid = 1'b0;
      total++; if (resp_valid !== (k == 5 || k == 11)) begin bad++; $display("FAIL b2b_resp_valid k=%0d got=%b", k, resp_valid); end
      total++; if (req_ready !== (k == 5 || k == 11)) begin bad++; $display("FAIL b2b_ready k=%0d got=%b", k, req_ready); end
      total++; if (bus_we !== (k == 8 || k == 9)) begin bad++; $display("FAIL b2b_we k=%0d got=%b", k, bus_we); end
      if (k == 5) begin
        total++; if (resp_rd_data !== 8'h5A) begin bad++; $display("FAIL b2b_rd got=%h want=5a", resp_rd_data); end
      end
      if (k == 6) begin
        total++; if (bus_addr !== 17'h0E840 || bus_wr_data !== 8'h96) begin bad++; $display("FAIL b2b_second_addr got=%h/%h want=0e840/96", bus_addr, bus_wr_data); end
      end
      if (k == 11) begin
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", resp_err); end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit acc;
    issue(17'h01000, 1'b1, 8'h77, acc);
    req_valid = 1'b0;
    total++; if (!acc) begin bad++; $display("FAIL rmid_accept timeout"); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_strobe !== 1'b1 || bus_we !== 1'b1) begin bad++; $display("FAIL rmid_strobe_pre got=%b%b want=11", bus_strobe, bus_we); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus_strobe !== 1'b0 || bus_we !== 1'b0) begin bad++; $display("FAIL rmid_async_drop got=%b%b want=00", bus_strobe, bus_we); end
    total++; if (bus_addr !== '0) begin bad++; $display("FAIL rmid_addr got=%h want=0", bus_addr); end
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_resp k=%0d got=%b", k, resp_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready k=%0d got=%b", k, req_ready); end
    end
    rd_value = 8'hC3;
    issue(17'h00042, 1'b0, 8'h00, acc);
    req_valid = 1'b0;
    total++; if (!acc) begin bad++; $display("FAIL rmid_fresh_accept timeout"); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b1 || resp_rd_data !== 8'hC3) begin bad++; $display("FAIL rmid_fresh_read got=%b/%h want=1/c3", resp_valid, resp_rd_data); end
  endtask

  task automatic test_boundaries;
    logic [AW-1:0] addrs [4] = '{17'h0E7FF, 17'h0E800, 17'h0EFFF, 17'h0F000};
    logic          errs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit acc;
    for (int i = 0; i < 4; i++) begin
      issue(addrs[i], 1'b1, 8'h40 + 8'(i), acc);
      req_valid = 1'b0;
      total++; if (!acc) begin bad++; $display("FAIL bound_accept i=%0d timeout", i); end
      for (int k = 1; k <= 5; k++) begin
        @(posedge clk); #1;
        if (k == 2) begin
          total++; if (bus_we !== !errs[i]) begin bad++; $display("FAIL bound_we addr=%h got=%b want=%b", addrs[i], bus_we, !errs[i]); end
        end
      end
      total++; if (resp_valid !== 1'b1 || resp_err !== errs[i]) begin bad++; $display("FAIL bound_err addr=%h got=%b/%b want=1/%b", addrs[i], resp_valid, resp_err, errs[i]); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_wr_data = '0; req_we = 1'b0; rd_value = '0;
    #2;
    test_reset;
    test_read;
    test_write_ram;
    test_write_rom;
    test_back_to_back;
    test_reset_mid;
    test_boundaries;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
